wdata_chan_mngr: RTL

Write-data channel manager that sits directly downstream of the request channel manager. It counts address beats already accepted on the request channel and arbitrates for the write-data bus. For each accepted request it sends one 128-bit data beat, carrying the ID/mask/data held at the head of the request manager's ID/data queue, then pops that entry. Requests with an all-zero mask carry no data (reads): they are popped without touching the bus.

---
 rtl/wdata_chan_mngr.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wdata_chan_mngr.sv
// Write-data channel manager: counts accepted address beats, arbitrates for the
// write-data bus and sends one beat per queued write; zero-mask entries are popped silently.
module wdata_chan_mngr #(
  parameter int PEND_MAX = 4,
  parameter int PEND_W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         next_rq,
  input  logic [3:0]   next_id,
  input  logic [15:0]  next_mask,
  input  logic [127:0] next_data,
  output logic         ren_id_data,
  output logic         req_wd,
  input  logic         gnt_wd,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [3:0]   w_id,
  output logic [15:0]  w_mask,
  output logic [127:0] w_data,
  output logic         w_last,
  output logic         pend_ovf
);

  typedef enum logic [1:0] {
    WDC_IDLE = 2'b00,
    WDC_WREQ = 2'b01,
    WDC_WOUT = 2'b10,
    WDC_DEFO = 2'b11
  } state_e;

  localparam logic [PEND_W-1:0] PEND_MAX_C = PEND_W'(PEND_MAX);

  state_e              state_q, state_d;
  logic [PEND_W-1:0]   pend_cnt_q, pend_cnt_d;
  logic                pend_ovf_q, pend_ovf_d;
  logic                head_ok;
  logic                mask_nz;
  logic                ren;
  logic                req;
  logic                wv;

  assign head_ok = (pend_cnt_q != '0);
  assign mask_nz = |next_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WDC_IDLE;
      pend_cnt_q <= '0;
      pend_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_cnt_q <= pend_cnt_d;
      pend_ovf_q <= pend_ovf_d;
    end
  end

  // Unknown decode inputs fall through to the default arms and lock the FSM up.
  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    req     = 1'b0;
    wv      = 1'b0;
    case (state_q)
      WDC_IDLE: begin
        case ({head_ok, mask_nz})
          2'b11:        state_d = WDC_WREQ;
          2'b10:        ren     = 1'b1;
          2'b00, 2'b01: state_d = WDC_IDLE;
          default:      state_d = WDC_DEFO;
        endcase
      end
      WDC_WREQ: begin
        req = 1'b1;
        case (gnt_wd)
          1'b1:    state_d = WDC_WOUT;
          1'b0:    state_d = WDC_WREQ;
          default: state_d = WDC_DEFO;
        endcase
      end
      WDC_WOUT: begin
        wv = 1'b1;
        case (w_ready)
          1'b1: begin
            ren     = 1'b1;
            state_d = WDC_IDLE;
          end
          1'b0:    state_d = WDC_WOUT;
          default: state_d = WDC_DEFO;
        endcase
      end
      WDC_DEFO: state_d = WDC_DEFO;
      default:  state_d = WDC_DEFO;
    endcase
  end

  // A push and a pop in the same cycle cancel; a push into a full count is the overflow.
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    pend_ovf_d = pend_ovf_q;
    if (next_rq && !ren) begin
      if (pend_cnt_q == PEND_MAX_C) begin
        pend_ovf_d = 1'b1;
      end else begin
        pend_cnt_d = pend_cnt_q + 1'b1;
      end
    end else if (!next_rq && ren && head_ok) begin
      pend_cnt_d = pend_cnt_q - 1'b1;
    end
  end

  assign ren_id_data = ren;
  assign req_wd      = req;
  assign w_valid     = wv;
  assign w_id        = next_id;
  assign w_mask      = next_mask;
  assign w_data      = next_data;
  assign w_last      = 1'b1;
  assign pend_ovf    = pend_ovf_q;

endmodule
